// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache: data word, address split and frame layout.
// The structs describe the default 16-frame geometry; the cache itself derives widths from NFRAMES.
package icache_dm_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_NFRAMES = 16;
  localparam int unsigned ICACHE_IDX_W   = $clog2(ICACHE_NFRAMES);
  localparam int unsigned ICACHE_TAG_W   = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

endpackage

// File: rtl/icache_dm_if.sv
// Datapath-side fetch port and memory-side read port of the instruction cache.
// slave is the cache's view; master is the view of the datapath plus memory around it.
interface icache_dm_if;
  import icache_dm_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-block instruction cache. Hits answer combinationally in the same
// cycle; a miss fills one frame from memory and the retried lookup then hits.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned NFRAMES = ICACHE_NFRAMES,
  parameter word_t       PC_INIT = 32'h0000_0000
) (
  input logic        CLK,
  input logic        nRST,
  icache_dm_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NFRAMES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam word_t MISS_ADDR_RST = PC_INIT & 32'hFFFF_FFFC;

  typedef enum logic {IDLE, FILL} icache_state_t;

  icache_state_t r_state, w_state_d;
  word_t         r_miss_addr, w_miss_addr_d;

  logic [NFRAMES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [NFRAMES];
  word_t              r_data [NFRAMES];

  logic [IDX_W-1:0] w_idx, w_miss_idx;
  logic [TAG_W-1:0] w_tag, w_miss_tag;
  logic             w_hit, w_fill;
  logic             w_unused_offset;

  assign w_idx      = bus.imemaddr[IDX_W+1:2];
  assign w_tag      = bus.imemaddr[31:IDX_W+2];
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = r_miss_addr[31:IDX_W+2];

  // Fetch addresses are word aligned; the byte offset carries no information.
  assign w_unused_offset = ^bus.imemaddr[1:0];

  assign w_hit = bus.imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  always_comb begin
    w_state_d     = r_state;
    w_miss_addr_d = r_miss_addr;
    w_fill        = 1'b0;
    bus.ihit      = 1'b0;
    bus.imemload  = '0;
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    unique case (r_state)
      IDLE: begin
        bus.ihit = w_hit;
        if (w_hit) begin
          bus.imemload = r_data[w_idx];
        end
        if (bus.imemREN && !w_hit) begin
          w_state_d     = FILL;
          w_miss_addr_d = {bus.imemaddr[31:2], 2'b00};
        end
      end
      FILL: begin
        // Redirects and a dropped imemREN are ignored until the pending fill lands.
        bus.iREN  = 1'b1;
        bus.iaddr = r_miss_addr;
        if (!bus.iwait) begin
          w_fill    = 1'b1;
          w_state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= MISS_ADDR_RST;
      r_valid     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_miss_addr <= w_miss_addr_d;
      if (w_fill) begin
        r_valid[w_miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: the valid bit gates every use of them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fetch results are queued at request time and checked on ihit.
module tb_icache_dm;
  import icache_dm_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  icache_dm_if bus ();

  icache_dm #(
    .NFRAMES(16),
    .PC_INIT(32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int    n_vec = 0;
  int    n_err = 0;
  word_t sb_q[$];
  word_t exp_w;

  function automatic word_t mem_word(input word_t a);
    case (a)
      32'h0000_0040: return 32'h2001_0005;
      32'h0000_0080: return 32'h1234_5678;
      default:       return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Request addr and hold it until ihit. A miss must fill for nwait busy cycles plus the
  // data cycle and hit nwait+2 cycles after the request; a hit must answer in cycle 0.
  task automatic do_fetch(input word_t addr, input int nwait, input bit miss);
    int    cyc   = 0;
    int    fills = 0;
    bit    got   = 1'b0;
    word_t exp;
    sb_q.push_back(mem_word(addr));
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    while (!got && cyc < 40) begin
      bus.iwait = (fills < nwait);
      bus.iload = bus.iwait ? 32'hDEAD_BEEF : mem_word(addr);
      @(negedge CLK);
      if (bus.ihit) begin
        got = 1'b1;
        exp = sb_q.pop_front();
        chk("fetch_data", bus.imemload, exp);
        chk("fetch_cycle", 32'(cyc), miss ? 32'(nwait + 2) : 32'd0);
        chk("hit_iren", 32'(bus.iREN), 32'd0);
      end else if (bus.iREN) begin
        chk("fill_iaddr", bus.iaddr, addr);
        fills++;
      end
      tick();
      cyc++;
    end
    chk("fetch_done", 32'(got), 32'd1);
  endtask

  initial begin
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    tick();
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_iren", 32'(bus.iREN), 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    tick();

    // Cold miss, then a hit on the same word
    do_fetch(32'h0000_0040, 3, 1'b1);
    do_fetch(32'h0000_0040, 0, 1'b0);

    // Conflict at index 0: 0x80 evicts 0x40, which then misses again
    do_fetch(32'h0000_0080, 2, 1'b1);
    do_fetch(32'h0000_0080, 0, 1'b0);
    do_fetch(32'h0000_0040, 1, 1'b1);

    // Redirect during a fill to 0x100
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    bus.iwait    = 1'b1;
    @(negedge CLK);
    chk("redir_miss", 32'(bus.ihit), 32'd0);
    tick();
    bus.imemaddr = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      bus.iwait = (k < 2);
      bus.iload = bus.iwait ? 32'hDEAD_BEEF : mem_word(32'h0000_0100);
      @(negedge CLK);
      chk("redir_iren", 32'(bus.iREN), 32'd1);
      chk("redir_iaddr", bus.iaddr, 32'h0000_0100);
      tick();
    end
    bus.iwait    = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    #1;
    sb_q.push_back(mem_word(32'h0000_0100));
    chk("redir_probe_hit", 32'(bus.ihit), 32'd1);
    exp_w = sb_q.pop_front();
    chk("redir_probe_data", bus.imemload, exp_w);
    bus.imemaddr = 32'h0000_0200;
    @(negedge CLK);
    chk("redir_new_miss", 32'(bus.ihit), 32'd0);
    chk("redir_new_iren0", 32'(bus.iREN), 32'd0);
    tick();
    bus.iwait = 1'b0;
    bus.iload = mem_word(32'h0000_0200);
    @(negedge CLK);
    chk("redir_new_iren1", 32'(bus.iREN), 32'd1);
    chk("redir_new_iaddr", bus.iaddr, 32'h0000_0200);
    tick();
    do_fetch(32'h0000_0200, 0, 1'b0);

    // Reset in the middle of a fill flushes the cache
    do_fetch(32'h0000_0044, 1, 1'b1);
    bus.imemaddr = 32'h0000_0048;
    bus.iwait    = 1'b1;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("rstfill_iren_pre", 32'(bus.iREN), 32'd1);
    nRST        = 1'b0;
    bus.imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rstfill_iren", 32'(bus.iREN), 32'd0);
    chk("rstfill_iaddr", bus.iaddr, 32'd0);
    tick();
    do_fetch(32'h0000_0044, 1, 1'b1);

    // No request on a valid frame: no hit, no data, no fill
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0044;
    @(negedge CLK);
    chk("noreq_ihit", 32'(bus.ihit), 32'd0);
    chk("noreq_imemload", bus.imemload, 32'd0);
    chk("noreq_iren", 32'(bus.iREN), 32'd0);
    tick();
    @(negedge CLK);
    chk("noreq_iren_next", 32'(bus.iREN), 32'd0);
    tick();
    do_fetch(32'h0000_0044, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
